// File: rtl/shift_reg_sched_pkg.sv
// Shared types for the shift-register scheduler: FSM states, in-flight tag and round-robin pick.
// Combinational helpers only; no timing or flow-control behaviour lives here.
package shift_reg_sched_pkg;

    localparam int ID_MAX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

    // First requester at or after ptr (wrapping over n); returns ptr when nobody asks.
    function automatic logic [ID_MAX_W-1:0] rr_pick(input logic [7:0]          req,
                                                    input logic [ID_MAX_W-1:0] ptr,
                                                    input int                  n);
        logic [ID_MAX_W-1:0] pick;
        logic [ID_MAX_W-1:0] idx;
        int                  sum;
        pick = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (i < n) begin
                sum = (int'(ptr) + i) % n;
                idx = ID_MAX_W'(sum);
                if (req[idx]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/shift_reg_sched_if.sv
// Requester, ShiftRegister and response signals of the scheduler; slave = scheduler side.
// Requests use valid/ready per beat; responses are valid-only with no backpressure.
interface shift_reg_sched_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    sr_enable;
    logic [DATA_W-1:0]       sr_din;
    logic [DATA_W-1:0]       sr_dout;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;
    logic                    busy;

    modport slave (
        input  req_valid, req_last, req_data, sr_dout,
        output req_ready, sr_enable, sr_din, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_last, req_data, sr_dout,
        input  req_ready, sr_enable, sr_din, rsp_valid, rsp_id, rsp_data, busy
    );

endinterface

// File: rtl/shift_reg_sched_sr_tag_pipe.sv
// DEPTH-deep {valid,id} shadow of the ShiftRegister; shifts only when i_en, so a tag leaves
// the last stage after DEPTH enabled edges. No backpressure: it freezes with the datapath.
module sr_tag_pipe
    import shift_reg_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  tag_t i_tag,
    output tag_t o_tag,
    output logic o_any_valid
);

    tag_t r_stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (i_en) begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    always_comb begin
        o_any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) o_any_valid = o_any_valid | r_stage[i].valid;
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/shift_reg_sched.sv
// Round-robin burst scheduler sharing one DEPTH-stage ShiftRegister; a word returns, tagged with its
// owner, one cycle after its DEPTH-th enabled edge. Grant holder stalls the pipe by dropping valid.
module shift_reg_sched
    import shift_reg_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int BURST_MAX = 16
) (
    input  logic               clk,
    input  logic               rst,
    shift_reg_sched_if.slave   io_bus
);

    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BEAT_W = $clog2(BURST_MAX + 1);
    localparam int FLSH_W = $clog2(DEPTH + 1);

    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);
    localparam logic [FLSH_W-1:0] FLUSH_LEN = FLSH_W'(DEPTH);

    state_t              r_state, w_state_nxt;
    logic [ID_W-1:0]     r_grant, w_grant_nxt;
    logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
    logic [BEAT_W-1:0]   r_beats, w_beats_nxt;
    logic [FLSH_W-1:0]   r_flush, w_flush_nxt;
    logic                r_adv;

    logic [N_REQ-1:0]    w_ready;
    logic                w_sr_enable;
    logic [DATA_W-1:0]   w_sr_din;
    tag_t                w_tag_in;
    tag_t                w_tag_out;
    logic                w_any_vld;
    logic                w_rsp_vld;
    logic [DATA_W-1:0]   w_req_word [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_word
        assign w_req_word[g] = io_bus.req_data[g*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_beats <= '0;
            r_flush <= '0;
            r_adv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_beats <= w_beats_nxt;
            r_flush <= w_flush_nxt;
            r_adv   <= w_sr_enable;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_beats_nxt = r_beats;
        w_flush_nxt = r_flush;
        w_ready     = '0;
        w_sr_enable = 1'b0;
        w_sr_din    = '0;
        w_tag_in    = '0;
        unique case (r_state)
            IDLE: begin
                if (|io_bus.req_valid) begin
                    w_grant_nxt = ID_W'(rr_pick(8'(io_bus.req_valid), ID_MAX_W'(r_ptr), N_REQ));
                    w_beats_nxt = '0;
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                // Grant is held through stalls; only the owner's valid moves the pipe.
                if (io_bus.req_valid[r_grant]) begin
                    w_ready[r_grant] = 1'b1;
                    w_sr_enable      = 1'b1;
                    w_sr_din         = w_req_word[r_grant];
                    w_tag_in.valid   = 1'b1;
                    w_tag_in.id      = ID_MAX_W'(r_grant);
                    w_beats_nxt      = r_beats + BEAT_W'(1);
                    if (io_bus.req_last[r_grant] || (r_beats == BEAT_LAST)) begin
                        w_ptr_nxt   = (r_grant == LAST_ID) ? '0 : r_grant + ID_W'(1);
                        w_flush_nxt = FLUSH_LEN;
                        w_state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                w_sr_enable = 1'b1;
                w_flush_nxt = r_flush - FLSH_W'(1);
                if (r_flush == FLSH_W'(1)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    sr_tag_pipe #(.DEPTH(DEPTH)) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_sr_enable),
        .i_tag       (w_tag_in),
        .o_tag       (w_tag_out),
        .o_any_valid (w_any_vld)
    );

    // r_adv gates stalls: a tag parked in the last stage must not repeat its response.
    assign w_rsp_vld = r_adv & w_tag_out.valid;

    assign io_bus.req_ready = w_ready;
    assign io_bus.sr_enable = w_sr_enable;
    assign io_bus.sr_din    = w_sr_din;
    assign io_bus.rsp_valid = w_rsp_vld;
    assign io_bus.rsp_id    = w_rsp_vld ? ID_W'(w_tag_out.id) : '0;
    assign io_bus.rsp_data  = w_rsp_vld ? io_bus.sr_dout : '0;
    assign io_bus.busy      = (r_state != IDLE) || w_any_vld;

endmodule
